// File: rtl/mem_map_pkg.sv
// Shared constants for the memory-mapped responder: register offsets, CTRL/STATUS
// bit positions, reset values and the CTRL read-back packing helper.
package mem_map_pkg;

    localparam logic [2:0] MAP_CTRL    = 3'd0;
    localparam logic [2:0] MAP_STATUS  = 3'd1;
    localparam logic [2:0] MAP_TMR_CNT = 3'd2;
    localparam logic [2:0] MAP_TMR_CMP = 3'd3;
    localparam logic [2:0] MAP_TMR_RLD = 3'd4;
    localparam logic [2:0] MAP_GPIO_OUT = 3'd5;
    localparam logic [2:0] MAP_GPIO_IN = 3'd6;
    localparam logic [2:0] MAP_SCRATCH = 3'd7;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_RELOAD_BIT = 1;
    localparam int CTRL_INTEN_BIT  = 2;
    localparam int CTRL_PRES_LSB   = 4;

    localparam int STATUS_OVF_BIT = 0;
    localparam int STATUS_CMP_BIT = 1;

    localparam logic [15:0] REG_RESET  = 16'h0000;
    localparam logic [3:0]  PRES_RESET = 4'd0;
    localparam logic        BIT_RESET  = 1'b0;

    function automatic logic [15:0] packCtrl(input logic en, input logic reload,
                                             input logic intEn, input logic [3:0] pres);
        logic [15:0] v;
        v = 16'h0000;
        v[CTRL_EN_BIT] = en;
        v[CTRL_RELOAD_BIT] = reload;
        v[CTRL_INTEN_BIT] = intEn;
        v[CTRL_PRES_LSB +: 4] = pres;
        return v;
    endfunction

endpackage

// File: rtl/map_timer.sv
// Prescaled 16-bit timer: prescaler, counter with reload, overflow/compare flags.
// Prescaler only exists when MEM_MAP_PRESCALE_EN is defined; otherwise every enabled cycle ticks.
module map_timer
    import mem_map_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
`ifdef MEM_MAP_PRESCALE_EN
    input  logic [3:0]  i_presSel,
    input  logic        i_ctrlWr,
`endif
    input  logic        i_enable,
    input  logic        i_autoReload,
    input  logic        i_cntWrEn,
    input  logic [15:0] i_wrData,
    input  logic [15:0] i_cmpValue,
    input  logic [15:0] i_rldValue,
    input  logic        i_clrOvf,
    input  logic        i_clrCmp,
    output logic [15:0] o_count,
    output logic        o_ovfFlag,
    output logic        o_cmpFlag
);

    logic [15:0] cnt_r;
    logic        ovf_r;
    logic        cmp_r;
    logic        tick_s;
    logic [15:0] cntNext_s;
    logic        setOvf_s;
    logic        setCmp_s;

`ifdef MEM_MAP_PRESCALE_EN
    logic [15:0] presCnt_r;
    logic [15:0] presLimit_s;

    // Tick when the prescaler reaches 2^n-1 while enabled.
    always_comb begin
        presLimit_s = (16'd1 << i_presSel) - 16'd1;
        tick_s = i_enable & (presCnt_r == presLimit_s);
    end

    // Prescaler restarts on tick, on any CTRL write and while disabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presCnt_r <= REG_RESET;
        end else if (i_ctrlWr || !i_enable || tick_s) begin
            presCnt_r <= REG_RESET;
        end else begin
            presCnt_r <= presCnt_r + 16'd1;
        end
    end
`else
    // Without a prescaler every enabled cycle is a tick.
    always_comb begin
        tick_s = i_enable;
    end
`endif

    // Next count and flag-set events; a bus write to the counter suppresses the tick.
    always_comb begin
        cntNext_s = cnt_r;
        setOvf_s = 1'b0;
        setCmp_s = 1'b0;
        if (i_cntWrEn) begin
            cntNext_s = i_wrData;
        end else if (tick_s) begin
            if (cnt_r == 16'hFFFF) begin
                setOvf_s = 1'b1;
                cntNext_s = i_autoReload ? i_rldValue : 16'h0000;
            end else begin
                cntNext_s = cnt_r + 16'd1;
            end
            setCmp_s = (cntNext_s == i_cmpValue);
        end else begin
            cntNext_s = cnt_r;
        end
    end

    // Counter and sticky flags; a set event beats a coincident clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r <= REG_RESET;
            ovf_r <= BIT_RESET;
            cmp_r <= BIT_RESET;
        end else begin
            cnt_r <= cntNext_s;
            ovf_r <= setOvf_s | (ovf_r & ~i_clrOvf);
            cmp_r <= setCmp_s | (cmp_r & ~i_clrCmp);
        end
    end

    assign o_count = cnt_r;
    assign o_ovfFlag = ovf_r;
    assign o_cmpFlag = cmp_r;

endmodule

// File: rtl/mem_map_responder.sv
// Target side of the memory-mapped region: decode, CTRL/CMP/RLD/GPIO/scratch registers,
// GPIO input synchronizer and combinational read mux. MEM_MAP_PRESCALE_EN enables the prescaler.
module mem_map_responder
    import mem_map_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_memAddr,
    input  logic [15:0] i_memData,
    input  logic        i_memMapWrEn,
    output logic [15:0] o_mapReadData,
    input  logic [15:0] i_gpioIn,
    output logic [15:0] o_gpioOut,
    output logic        o_intr
);

    logic [2:0]  offset_s;
    logic [7:0]  wrSel_s;
    logic        ctrlEn_r;
    logic        ctrlReload_r;
    logic        ctrlIntEn_r;
    logic [3:0]  ctrlPres_s;
    logic [15:0] cmp_r;
    logic [15:0] rld_r;
    logic [15:0] gpioOut_r;
    logic [15:0] scratch_r;
    logic [15:0] gpioSync1_r;
    logic [15:0] gpioSync2_r;
    logic [15:0] count_s;
    logic        ovfFlag_s;
    logic        cmpFlag_s;
    logic        unusedAddrBits_s;

    assign offset_s = i_memAddr[2:0];
    assign unusedAddrBits_s = ^i_memAddr[15:3];

    // One-hot write strobe per register offset.
    always_comb begin
        wrSel_s = 8'h00;
        if (i_memMapWrEn) begin
            wrSel_s[offset_s] = 1'b1;
        end else begin
            wrSel_s = 8'h00;
        end
    end

`ifdef MEM_MAP_PRESCALE_EN
    logic [3:0] ctrlPres_r;

    // Prescale select field, only stored when the prescaler is built.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrlPres_r <= PRES_RESET;
        end else if (wrSel_s[MAP_CTRL]) begin
            ctrlPres_r <= i_memData[CTRL_PRES_LSB +: 4];
        end else begin
            ctrlPres_r <= ctrlPres_r;
        end
    end
    assign ctrlPres_s = ctrlPres_r;
`else
    assign ctrlPres_s = PRES_RESET;
`endif

    // Bus-writable configuration and data registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrlEn_r     <= BIT_RESET;
            ctrlReload_r <= BIT_RESET;
            ctrlIntEn_r  <= BIT_RESET;
            cmp_r        <= REG_RESET;
            rld_r        <= REG_RESET;
            gpioOut_r    <= REG_RESET;
            scratch_r    <= REG_RESET;
        end else begin
            if (wrSel_s[MAP_CTRL]) begin
                ctrlEn_r     <= i_memData[CTRL_EN_BIT];
                ctrlReload_r <= i_memData[CTRL_RELOAD_BIT];
                ctrlIntEn_r  <= i_memData[CTRL_INTEN_BIT];
            end
            if (wrSel_s[MAP_TMR_CMP]) cmp_r <= i_memData;
            if (wrSel_s[MAP_TMR_RLD]) rld_r <= i_memData;
            if (wrSel_s[MAP_GPIO_OUT]) gpioOut_r <= i_memData;
            if (wrSel_s[MAP_SCRATCH]) scratch_r <= i_memData;
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gpioSync1_r <= REG_RESET;
            gpioSync2_r <= REG_RESET;
        end else begin
            gpioSync1_r <= i_gpioIn;
            gpioSync2_r <= gpioSync1_r;
        end
    end

    map_timer uTimer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
`ifdef MEM_MAP_PRESCALE_EN
        .i_presSel    (ctrlPres_s),
        .i_ctrlWr     (wrSel_s[MAP_CTRL]),
`endif
        .i_enable     (ctrlEn_r),
        .i_autoReload (ctrlReload_r),
        .i_cntWrEn    (wrSel_s[MAP_TMR_CNT]),
        .i_wrData     (i_memData),
        .i_cmpValue   (cmp_r),
        .i_rldValue   (rld_r),
        .i_clrOvf     (wrSel_s[MAP_STATUS] & i_memData[STATUS_OVF_BIT]),
        .i_clrCmp     (wrSel_s[MAP_STATUS] & i_memData[STATUS_CMP_BIT]),
        .o_count      (count_s),
        .o_ovfFlag    (ovfFlag_s),
        .o_cmpFlag    (cmpFlag_s)
    );

    // Combinational read mux; reads never change state.
    always_comb begin
        o_mapReadData = REG_RESET;
        case (offset_s)
            MAP_CTRL:     o_mapReadData = packCtrl(ctrlEn_r, ctrlReload_r, ctrlIntEn_r, ctrlPres_s);
            MAP_STATUS:   o_mapReadData = {14'd0, cmpFlag_s, ovfFlag_s};
            MAP_TMR_CNT:  o_mapReadData = count_s;
            MAP_TMR_CMP:  o_mapReadData = cmp_r;
            MAP_TMR_RLD:  o_mapReadData = rld_r;
            MAP_GPIO_OUT: o_mapReadData = gpioOut_r;
            MAP_GPIO_IN:  o_mapReadData = gpioSync2_r;
            MAP_SCRATCH:  o_mapReadData = scratch_r;
            default:      o_mapReadData = REG_RESET;
        endcase
    end

    assign o_gpioOut = gpioOut_r;
    assign o_intr = ctrlIntEn_r & (ovfFlag_s | cmpFlag_s);

endmodule

// File: tb/tb_mem_map_responder.sv
// Directed self-checking bench for mem_map_responder; expectations follow MEM_MAP_PRESCALE_EN.
module tb_mem_map_responder;

    logic        clk;
    logic        rst;
    logic [15:0] memAddr;
    logic [15:0] memData;
    logic        memMapWrEn;
    logic [15:0] mapReadData;
    logic [15:0] gpioIn;
    logic [15:0] gpioOut;
    logic        intr;

    int vecCount = 0;
    int missCount = 0;

    mem_map_responder dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_memAddr     (memAddr),
        .i_memData     (memData),
        .i_memMapWrEn  (memMapWrEn),
        .o_mapReadData (mapReadData),
        .i_gpioIn      (gpioIn),
        .o_gpioOut     (gpioOut),
        .o_intr        (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        memAddr = addr;
        memData = data;
        memMapWrEn = 1'b1;
        @(posedge clk);
        #1;
        memMapWrEn = 1'b0;
    endtask

    task automatic checkRead(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        memAddr = addr;
        #1;
        checkVal(tag, mapReadData, exp);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        memAddr = 16'h0000;
        memData = 16'h0000;
        memMapWrEn = 1'b0;
        gpioIn = 16'h0000;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(1);

        // Reset state
        for (int i = 0; i < 8; i++) begin
            checkRead($sformatf("rst_off%0d", i), 16'(i), 16'h0000);
        end
        checkVal("rst_intr", {15'd0, intr}, 16'h0000);
        checkVal("rst_gpioOut", gpioOut, 16'h0000);

        // GPIO_OUT and aliased SCRATCH write
        busWrite(16'hC005, 16'hA5A5);
        checkVal("gpioOut", gpioOut, 16'hA5A5);
        busWrite(16'hC00F, 16'h1234);
        checkRead("scratch", 16'h0007, 16'h1234);
        checkRead("scratch_alias", 16'hC3FF, 16'h1234);

        // Overflow with auto-reload and interrupt
        busWrite(16'hC004, 16'h0100);
        busWrite(16'hC002, 16'hFFFE);
        busWrite(16'hC000, 16'h0007);
        waitCycles(2);
        checkRead("ovf_cnt", 16'hC002, 16'h0100);
        checkRead("ovf_status", 16'hC001, 16'h0001);
        checkRead("ovf_status_reread", 16'hC001, 16'h0001);
        checkVal("ovf_intr", {15'd0, intr}, 16'h0001);
        busWrite(16'hC001, 16'h0001);
        checkRead("ovf_w1c", 16'hC001, 16'h0000);
        checkVal("ovf_intr_clr", {15'd0, intr}, 16'h0000);
        busWrite(16'hC000, 16'h0000);

        // Compare flag, then W1C coincident with a set
        busWrite(16'hC003, 16'h0010);
        busWrite(16'hC002, 16'h000E);
        busWrite(16'hC000, 16'h0001);
        waitCycles(2);
        checkRead("cmp_cnt", 16'hC002, 16'h0010);
        checkRead("cmp_status", 16'hC001, 16'h0002);
        busWrite(16'hC001, 16'h0002);
        checkRead("cmp_w1c", 16'hC001, 16'h0000);
        busWrite(16'hC002, 16'h000F);
        checkRead("cnt_write_wins", 16'hC002, 16'h000F);
        busWrite(16'hC001, 16'h0002);
        checkRead("cmp_set_wins", 16'hC001, 16'h0002);
        checkRead("cmp_set_cnt", 16'hC002, 16'h0010);
        checkVal("cmp_intr_masked", {15'd0, intr}, 16'h0000);
        busWrite(16'hC000, 16'h0000);

        // Prescaler behaviour
        busWrite(16'hC002, 16'h0000);
        busWrite(16'hC000, 16'h0031);
`ifdef MEM_MAP_PRESCALE_EN
        checkRead("pres_ctrl", 16'hC000, 16'h0031);
        waitCycles(7);
        checkRead("pres_cnt7", 16'hC002, 16'h0000);
        waitCycles(1);
        checkRead("pres_cnt8", 16'hC002, 16'h0001);
        waitCycles(8);
        checkRead("pres_cnt16", 16'hC002, 16'h0002);
`else
        checkRead("pres_ctrl", 16'hC000, 16'h0001);
        waitCycles(1);
        checkRead("pres_cnt1", 16'hC002, 16'h0001);
        waitCycles(1);
        checkRead("pres_cnt2", 16'hC002, 16'h0002);
`endif
        busWrite(16'hC000, 16'h0000);

        // GPIO input synchronizer latency
        @(negedge clk);
        gpioIn = 16'h00FF;
        memAddr = 16'hC006;
        waitCycles(1);
        checkRead("gpioIn_1cyc", 16'hC006, 16'h0000);
        waitCycles(1);
        checkRead("gpioIn_2cyc", 16'hC006, 16'h00FF);
        busWrite(16'hC006, 16'h1234);
        checkRead("gpioIn_ro", 16'hC006, 16'h00FF);

        // Reset mid-count
        busWrite(16'hC000, 16'h0005);
        waitCycles(3);
        @(negedge clk);
        rst = 1'b1;
        waitCycles(1);
        checkRead("midrst_cnt", 16'hC002, 16'h0000);
        checkRead("midrst_ctrl", 16'hC000, 16'h0000);
        checkRead("midrst_scratch", 16'hC007, 16'h0000);
        checkVal("midrst_gpioOut", gpioOut, 16'h0000);
        rst = 1'b0;
        waitCycles(2);
        checkRead("postrst_cnt", 16'hC002, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
